// File: rtl/mem_pkg.sv
// Shared definitions for the backing memory: funct3 size codes, FSM states, op type.
package mem_pkg;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
    typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: merges stores into the stored word, extends loads, flags bad accesses.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  mode,
    input  mem_op_t     op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] write_data,
    output logic [31:0] store_word,
    output logic [31:0] load_val,
    output logic        bad
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        store_word = word;
        load_val   = '0;
        bad        = 1'b0;
        byte_v     = word[{lane, 3'b000} +: 8];
        half_v     = word[{lane[1], 4'b0000} +: 16];
        case (mode)
            MODE_B: begin
                load_val = {{24{byte_v[7]}}, byte_v};
                store_word[{lane, 3'b000} +: 8] = write_data[7:0];
            end
            MODE_BU: begin
                load_val = {24'b0, byte_v};
                bad      = (op == OP_WRITE);
            end
            MODE_H: begin
                load_val = {{16{half_v[15]}}, half_v};
                store_word[{lane[1], 4'b0000} +: 16] = write_data[15:0];
                bad      = lane[0];
            end
            MODE_HU: begin
                load_val = {16'b0, half_v};
                bad      = lane[0] | (op == OP_WRITE);
            end
            MODE_W: begin
                load_val   = word;
                store_word = write_data;
                bad        = (lane != 2'b00);
            end
            default: bad = 1'b1;
        endcase
        // A rejected access must neither disturb the array nor leak data.
        if (bad) begin
            load_val   = '0;
            store_word = word;
        end
    end

endmodule

// File: rtl/main_mem_backing.sv
// Fixed-latency word-addressed backing memory with B/H/W sizing and a one-cycle ready pulse.
module main_mem_backing
    import mem_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 32,
    parameter int    DATA_WIDTH  = 32,
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 4,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [2:0]            addr_mode,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  ready,
    output logic                  err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    mem_state_t             state;
    logic [CNT_W-1:0]       cnt;
    mem_op_t                op_q;
    logic [2:0]             mode_q;
    logic [IDX_W+1:0]       addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;

    logic [IDX_W-1:0]       idx;
    logic [31:0]            cur_word;
    logic [31:0]            store_word;
    logic [31:0]            load_val;
    logic                   bad;
    logic                   fire;
    logic                   unused_addr_hi;

    // Bits above the word index are deliberately dropped so addresses wrap.
    assign unused_addr_hi = ^addr[ADDR_WIDTH-1:IDX_W+2];

    assign idx      = addr_q[2 +: IDX_W];
    assign cur_word = mem[idx];
    assign fire     = (state == BUSY) && (cnt == '0);

    mem_lane_align u_align (
        .mode       (mode_q),
        .op         (op_q),
        .lane       (addr_q[1:0]),
        .word       (cur_word),
        .write_data (wdata_q),
        .store_word (store_word),
        .load_val   (load_val),
        .bad        (bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_READ;
            mode_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                // DONE also accepts so a held request chains straight into the next access.
                IDLE, DONE: begin
                    if (req_read || req_write) begin
                        op_q    <= req_write ? OP_WRITE : OP_READ;
                        mode_q  <= addr_mode;
                        addr_q  <= addr[IDX_W+1:0];
                        wdata_q <= write_data;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        ready <= 1'b1;
                        err   <= bad;
                        if (op_q == OP_READ) read_data <= load_val;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fire && op_q == OP_WRITE && !bad) mem[idx] <= store_word;
    end

endmodule

// File: tb/tb_main_mem_backing.sv
// Directed bench for main_mem_backing: sizing, errors, latency, wrap, collision, reset abort.
module tb_main_mem_backing;
    localparam int LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        req_read;
    logic        req_write;
    logic [2:0]  addr_mode;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    main_mem_backing #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT),
        .INIT_FILE   ("")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_read   (req_read),
        .req_write  (req_write),
        .addr_mode  (addr_mode),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Runs one access; inputs are scrambled after acceptance to prove they are latched.
    task automatic access(input logic rd, input logic wr, input logic [2:0] mode,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic e, output int lat);
        @(negedge clk);
        req_read = rd; req_write = wr; addr_mode = mode; addr = a; write_data = wd;
        @(posedge clk);
        #1;
        addr = a ^ 32'h4; write_data = ~wd; addr_mode = mode ^ 3'b010;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = n;
                break;
            end
        end
        rdata = read_data;
        e = err;
        req_read = 1'b0; req_write = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_pulse_1cyc", {31'b0, ready}, 32'h0);
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    logic        seen;

    initial begin
        rst_n = 1'b0; req_read = 1'b0; req_write = 1'b0;
        addr_mode = 3'b000; addr = '0; write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_rdata", read_data, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e, lat);
        chk("sw_lat", 32'(lat), 32'(LAT));
        chk("sw_err", {31'b0, e}, 32'h0);
        access(1, 0, 3'b010, 32'h10, 32'h0, rd, e, lat);
        chk("lw_lat", 32'(lat), 32'(LAT));
        chk("lw_data", rd, 32'hDEADBEEF);

        access(0, 1, 3'b000, 32'h13, 32'h00000080, rd, e, lat);
        chk("sb_err", {31'b0, e}, 32'h0);
        access(1, 0, 3'b000, 32'h13, 32'h0, rd, e, lat);
        chk("lb_sext", rd, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h13, 32'h0, rd, e, lat);
        chk("lbu_zext", rd, 32'h00000080);
        access(1, 0, 3'b010, 32'h10, 32'h0, rd, e, lat);
        chk("lw_after_sb", rd, 32'h80ADBEEF);

        access(1, 0, 3'b001, 32'h11, 32'h0, rd, e, lat);
        chk("lh_mis_err", {31'b0, e}, 32'h1);
        chk("lh_mis_data", rd, 32'h0);
        access(1, 0, 3'b010, 32'h10, 32'h0, rd, e, lat);
        chk("lw_unchanged", rd, 32'h80ADBEEF);

        // Collision is a write; read_data must hold the previous load result.
        access(1, 1, 3'b010, 32'h20, 32'h12345678, rd, e, lat);
        chk("coll_err", {31'b0, e}, 32'h0);
        chk("rdata_hold", rd, 32'h80ADBEEF);
        access(1, 0, 3'b010, 32'h20, 32'h0, rd, e, lat);
        chk("coll_lw", rd, 32'h12345678);

        access(1, 0, 3'b101, 32'h22, 32'h0, rd, e, lat);
        chk("lhu_hi", rd, 32'h00001234);
        access(1, 0, 3'b001, 32'h20, 32'h0, rd, e, lat);
        chk("lh_lo", rd, 32'h00005678);
        access(0, 1, 3'b001, 32'h22, 32'hFFFF8001, rd, e, lat);
        chk("sh_err", {31'b0, e}, 32'h0);
        access(1, 0, 3'b001, 32'h22, 32'h0, rd, e, lat);
        chk("lh_sext", rd, 32'hFFFF8001);
        access(1, 0, 3'b100, 32'h21, 32'h0, rd, e, lat);
        chk("lbu_l1", rd, 32'h00000056);

        access(0, 1, 3'b100, 32'h20, 32'h000000FF, rd, e, lat);
        chk("sbu_illegal", {31'b0, e}, 32'h1);
        access(0, 1, 3'b010, 32'h22, 32'hCAFEF00D, rd, e, lat);
        chk("sw_mis_err", {31'b0, e}, 32'h1);
        access(1, 0, 3'b010, 32'h20, 32'h0, rd, e, lat);
        chk("lw_no_bad_wr", rd, 32'h80015678);
        access(1, 0, 3'b011, 32'h20, 32'h0, rd, e, lat);
        chk("mode011_err", {31'b0, e}, 32'h1);
        chk("mode011_data", rd, 32'h0);
        access(1, 0, 3'b010, 32'h21, 32'h0, rd, e, lat);
        chk("lw_mis_err", {31'b0, e}, 32'h1);

        access(0, 1, 3'b010, 32'h1000, 32'hA5A5A5A5, rd, e, lat);
        access(1, 0, 3'b010, 32'h0, 32'h0, rd, e, lat);
        chk("wrap_lw", rd, 32'hA5A5A5A5);

        access(0, 1, 3'b010, 32'h30, 32'h00000055, rd, e, lat);
        access(1, 0, 3'b010, 32'h10, 32'h0, rd, e, lat);
        chk("pre_rst_lw", rd, 32'h80ADBEEF);

        // Abort a write mid-BUSY: nothing must complete or commit.
        @(negedge clk);
        req_write = 1'b1; addr_mode = 3'b010; addr = 32'h30; write_data = 32'h11111111;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, ready}, 32'h0);
        chk("midrst_err", {31'b0, err}, 32'h0);
        chk("midrst_rdata", read_data, 32'h0);
        req_write = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        chk("midrst_no_ready", {31'b0, seen}, 32'h0);
        access(1, 0, 3'b010, 32'h30, 32'h0, rd, e, lat);
        chk("midrst_discard", rd, 32'h00000055);
        access(1, 0, 3'b010, 32'h20, 32'h0, rd, e, lat);
        chk("midrst_retain", rd, 32'h80015678);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
